// File: rtl/speed_controller.sv
// speed_controller
//   Frame-paced speed regulator with a crash/recover sequence.
//   A frame tick is taken from the rising edge of startOfFrame, which is
//   sampled in the clk domain. On each tick in RUN, the held key picks one of
//   three modes (accelerate / brake / coast). Each mode counts its own frames
//   and steps the speed by one after a full period. A crash zeroes the speed
//   and holds it there for a fixed number of frames. The block then ramps the
//   speed back up one step per frame until it reaches MIN_SPEED, and returns
//   to RUN.
//
// Ports
//   clk           system clock (the only clock)
//   resetN        synchronous reset, active low
//   startOfFrame  frame pulse, may stay high for several clk cycles
//   faster_key    accelerate request (level)
//   slower_key    brake request (level)
//   crash         collision event, acts on the next edge regardless of tick
//   speed         current speed, registered
//   at_max/at_min speed equals MAX_SPEED / MIN_SPEED
//   crashed       state is CRASH
//   recovering    state is RECOVER
module speed_controller #(
  parameter int SPEED_W           = 5,
  parameter int MIN_SPEED         = 12,
  parameter int MAX_SPEED         = 27,
  parameter int INIT_SPEED        = 12,
  parameter int ACCEL_FRAMES      = 10,
  parameter int BRAKE_FRAMES      = 10,
  parameter int COAST_FRAMES      = 30,
  parameter int CRASH_HOLD_FRAMES = 60
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               faster_key,
  input  logic               slower_key,
  input  logic               crash,
  output logic [SPEED_W-1:0] speed,
  output logic               at_max,
  output logic               at_min,
  output logic               crashed,
  output logic               recovering
);

  // Counter widths. A frame count of 1 would give $clog2 == 0, so keep at
  // least one bit; the counter then simply stays at 0.
  localparam int AW = (ACCEL_FRAMES      > 1) ? $clog2(ACCEL_FRAMES)      : 1;
  localparam int BW = (BRAKE_FRAMES      > 1) ? $clog2(BRAKE_FRAMES)      : 1;
  localparam int CW = (COAST_FRAMES      > 1) ? $clog2(COAST_FRAMES)      : 1;
  localparam int HW = (CRASH_HOLD_FRAMES > 1) ? $clog2(CRASH_HOLD_FRAMES) : 1;

  localparam logic [AW-1:0]      ACCEL_LAST = AW'(ACCEL_FRAMES - 1);
  localparam logic [BW-1:0]      BRAKE_LAST = BW'(BRAKE_FRAMES - 1);
  localparam logic [CW-1:0]      COAST_LAST = CW'(COAST_FRAMES - 1);
  localparam logic [HW-1:0]      HOLD_LAST  = HW'(CRASH_HOLD_FRAMES - 1);
  localparam logic [SPEED_W-1:0] MIN_S      = SPEED_W'(MIN_SPEED);
  localparam logic [SPEED_W-1:0] MAX_S      = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] INIT_S     = SPEED_W'(INIT_SPEED);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_CRASH   = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_ACCEL = 2'd0,
    M_BRAKE = 2'd1,
    M_COAST = 2'd2
  } mode_t;

  state_t               state_q, state_d;
  logic [SPEED_W-1:0]   speed_q, speed_d;
  logic [AW-1:0]        accel_q, accel_d;
  logic [BW-1:0]        brake_q, brake_d;
  logic [CW-1:0]        coast_q, coast_d;
  logic [HW-1:0]        hold_q,  hold_d;
  // sof_q is startOfFrame delayed by one clk (the edge-detect reference).
  logic                 sof_q,   sof_d;
  // mask_q suppresses the tick in the first cycle after reset when
  // startOfFrame was already high at the reset edge, so a frame pulse that
  // straddles reset release is not taken as a new frame.
  logic                 mask_q,  mask_d;

  logic                 tick;
  mode_t                mode;
  logic [SPEED_W-1:0]   speed_inc;

  assign tick      = startOfFrame & ~sof_q & ~mask_q;
  assign speed_inc = speed_q + 1'b1;

  // faster_key has priority over slower_key.
  always_comb begin
    mode = M_COAST;
    if (faster_key)      mode = M_ACCEL;
    else if (slower_key) mode = M_BRAKE;
  end

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    accel_d = accel_q;
    brake_d = brake_q;
    coast_d = coast_q;
    hold_d  = hold_q;
    sof_d   = startOfFrame;
    mask_d  = 1'b0;

    if (crash) begin
      // Crash wins over any tick in the same cycle.
      state_d = S_CRASH;
      speed_d = '0;
      accel_d = '0;
      brake_d = '0;
      coast_d = '0;
      hold_d  = '0;
    end else if (tick) begin
      unique case (state_q)
        S_RUN: begin
          // Inactive mode counters clear on every tick.
          accel_d = '0;
          brake_d = '0;
          coast_d = '0;
          unique case (mode)
            M_ACCEL: begin
              if (accel_q == ACCEL_LAST) begin
                if (speed_q < MAX_S) speed_d = speed_inc;
              end else begin
                accel_d = accel_q + 1'b1;
              end
            end
            M_BRAKE: begin
              if (brake_q == BRAKE_LAST) begin
                if (speed_q > MIN_S) speed_d = speed_q - 1'b1;
              end else begin
                brake_d = brake_q + 1'b1;
              end
            end
            default: begin
              if (coast_q == COAST_LAST) begin
                if (speed_q > MIN_S) speed_d = speed_q - 1'b1;
              end else begin
                coast_d = coast_q + 1'b1;
              end
            end
          endcase
        end

        S_CRASH: begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            state_d = S_RECOVER;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end

        S_RECOVER: begin
          // Climb from 0; arriving at MIN_SPEED hands control back to RUN
          // with every counter already clear.
          if (speed_inc == MIN_S) begin
            speed_d = MIN_S;
            state_d = S_RUN;
            accel_d = '0;
            brake_d = '0;
            coast_d = '0;
            hold_d  = '0;
          end else begin
            speed_d = speed_inc;
          end
        end

        default: begin
          state_d = S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= S_RUN;
      speed_q <= INIT_S;
      accel_q <= '0;
      brake_q <= '0;
      coast_q <= '0;
      hold_q  <= '0;
      sof_q   <= 1'b0;
      mask_q  <= startOfFrame;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      accel_q <= accel_d;
      brake_q <= brake_d;
      coast_q <= coast_d;
      hold_q  <= hold_d;
      sof_q   <= sof_d;
      mask_q  <= mask_d;
    end
  end

  assign speed      = speed_q;
  assign at_max     = (speed_q == MAX_S);
  assign at_min     = (speed_q == MIN_S);
  assign crashed    = (state_q == S_CRASH);
  assign recovering = (state_q == S_RECOVER);

endmodule

// File: tb/tb_speed_controller.sv
module tb_speed_controller;

  localparam int SPEED_W = 5;
  localparam int MIN_SP  = 12;
  localparam int MAX_SP  = 27;
  localparam int INIT_SP = 12;
  localparam int N_ACC   = 10;
  localparam int N_BRK   = 10;
  localparam int N_CST   = 30;
  localparam int N_HOLD  = 60;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               startOfFrame = 1'b0;
  logic               faster_key = 1'b0;
  logic               slower_key = 1'b0;
  logic               crash = 1'b0;
  logic [SPEED_W-1:0] speed;
  logic               at_max, at_min, crashed, recovering;

  int checks = 0;
  int errors = 0;

  speed_controller #(
    .SPEED_W(SPEED_W), .MIN_SPEED(MIN_SP), .MAX_SPEED(MAX_SP),
    .INIT_SPEED(INIT_SP), .ACCEL_FRAMES(N_ACC), .BRAKE_FRAMES(N_BRK),
    .COAST_FRAMES(N_CST), .CRASH_HOLD_FRAMES(N_HOLD)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .faster_key(faster_key), .slower_key(slower_key), .crash(crash),
    .speed(speed), .at_max(at_max), .at_min(at_min),
    .crashed(crashed), .recovering(recovering)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference ----------------
  // phase: "run", "crash" or "recover"; frames[] = frames accumulated toward
  // the next step of each run mode; hold = frames spent crashed.
  string m_phase = "run";
  int    m_speed = INIT_SP;
  int    frames[3] = '{0, 0, 0};
  int    hold = 0;
  bit    sof_seen = 1'b0;
  bit    m_valid = 1'b0;

  always @(posedge clk) begin
    bit is_tick;
    int m, period;
    is_tick = startOfFrame && !sof_seen;
    sof_seen = startOfFrame;          // a pulse already high at reset is not new
    if (!resetN) begin
      m_phase = "run"; m_speed = INIT_SP; frames = '{0, 0, 0}; hold = 0;
    end else if (crash) begin
      m_phase = "crash"; m_speed = 0; frames = '{0, 0, 0}; hold = 0;
    end else if (is_tick) begin
      if (m_phase == "run") begin
        m = faster_key ? 0 : (slower_key ? 1 : 2);
        period = (m == 0) ? N_ACC : ((m == 1) ? N_BRK : N_CST);
        for (int k = 0; k < 3; k++) if (k != m) frames[k] = 0;
        frames[m] = frames[m] + 1;
        if (frames[m] == period) begin
          frames[m] = 0;
          if (m == 0) m_speed = (m_speed < MAX_SP) ? m_speed + 1 : m_speed;
          else        m_speed = (m_speed > MIN_SP) ? m_speed - 1 : m_speed;
        end
      end else if (m_phase == "crash") begin
        hold = hold + 1;
        if (hold == N_HOLD) begin hold = 0; m_phase = "recover"; end
      end else begin
        m_speed = m_speed + 1;
        if (m_speed == MIN_SP) begin m_phase = "run"; frames = '{0, 0, 0}; end
      end
    end
    m_valid = 1'b1;
    #1;
    if (m_valid) begin
      checks++;
      if (speed !== SPEED_W'(m_speed) || at_max !== (m_speed == MAX_SP) ||
          at_min !== (m_speed == MIN_SP) || crashed !== (m_phase == "crash") ||
          recovering !== (m_phase == "recover")) begin
        errors++;
        $display("FAIL model t=%0t speed/max/min/crashed/recovering got %0d/%b/%b/%b/%b want %0d/%b/%b/%b/%b",
                 $time, speed, at_max, at_min, crashed, recovering, m_speed,
                 m_speed == MAX_SP, m_speed == MIN_SP, m_phase == "crash", m_phase == "recover");
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // n frames, each hi clk high then lo clk low
  task automatic frames_run(input int n, input int hi = 1, input int lo = 3);
    for (int f = 0; f < n; f++) begin
      startOfFrame = 1'b1;
      repeat (hi) @(negedge clk);
      startOfFrame = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic keys(input bit f, input bit s);
    faster_key = f; slower_key = s;
  endtask

  task automatic crash_pulse();
    crash = 1'b1; @(negedge clk); crash = 1'b0;
  endtask

  initial begin
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("reset_speed", speed, 12);
    chk("reset_at_min", at_min, 1);
    chk("reset_crashed", crashed, 0);
    resetN = 1'b1;
    @(negedge clk);

    keys(1, 0);
    frames_run(9);
    chk("accel_9_ticks", speed, 12);
    frames_run(1);
    chk("accel_10_ticks", speed, 13);
    frames_run(150);
    chk("accel_saturate", speed, 27);
    chk("at_max", at_max, 1);

    keys(0, 1);
    frames_run(70);
    chk("brake_to_20", speed, 20);
    keys(1, 1);
    frames_run(10);
    chk("both_keys_accel", speed, 21);
    keys(0, 1);
    frames_run(10);
    chk("brake_step", speed, 20);
    keys(0, 0);
    frames_run(29);
    chk("coast_29", speed, 20);
    frames_run(1);
    chk("coast_30", speed, 19);

    keys(1, 0);
    frames_run(10, 5, 2);
    chk("wide_sof_one_step", speed, 20);
    frames_run(50);
    chk("pre_crash", speed, 25);

    crash_pulse();
    chk("crash_speed", speed, 0);
    chk("crash_flag", crashed, 1);
    frames_run(59);
    chk("hold_59", crashed, 1);
    frames_run(1);
    chk("hold_60_recover", recovering, 1);
    frames_run(11);
    chk("recover_11", speed, 11);
    frames_run(1);
    chk("recover_12_speed", speed, 12);
    chk("recover_done", recovering, 0);

    crash_pulse();
    frames_run(60 + 5);
    chk("recover_at_5", speed, 5);
    crash_pulse();
    chk("recrash_speed", speed, 0);
    chk("recrash_flag", crashed, 1);
    frames_run(59);
    chk("rehold_59", crashed, 1);
    frames_run(1);
    chk("rehold_60", recovering, 1);

    crash_pulse();
    frames_run(20);
    resetN = 1'b0; @(negedge clk); resetN = 1'b1;
    chk("midcrash_reset_speed", speed, 12);
    chk("midcrash_reset_crashed", crashed, 0);
    frames_run(9);
    chk("post_reset_9", speed, 12);
    frames_run(1);
    chk("post_reset_10", speed, 13);

    // frame pulse straddling reset release is not a tick
    startOfFrame = 1'b1; resetN = 1'b0; @(negedge clk);
    resetN = 1'b1; repeat (3) @(negedge clk);
    startOfFrame = 1'b0; @(negedge clk);
    frames_run(9);
    chk("straddle_9", speed, 12);
    frames_run(1);
    chk("straddle_10", speed, 13);

    // randomized traffic checked every cycle by the model
    for (int f = 0; f < 1500; f++) begin
      int hi, lo;
      hi = $urandom_range(1, 4);
      lo = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) keys($urandom_range(0, 1), $urandom_range(0, 1));
      startOfFrame = 1'b1;
      for (int c = 0; c < hi + lo; c++) begin
        if (c == hi) startOfFrame = 1'b0;
        crash  = ($urandom_range(0, 599) == 0);
        resetN = ($urandom_range(0, 1999) != 0);
        @(negedge clk);
      end
      crash = 1'b0; resetN = 1'b1;
    end
    startOfFrame = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/speed_controller.md
SPEED_CONTROLLER -- requirements
Module: speed_controller

Interface
REQ-001 Parameter SPEED_W, default 5, width of the speed output in bits.
REQ-002 Parameter MIN_SPEED, default 12, lowest speed reachable in RUN.
REQ-003 Parameter MAX_SPEED, default 27, highest speed reachable in RUN.
REQ-004 Parameter INIT_SPEED, default 12, speed loaded at reset.
REQ-005 Parameter ACCEL_FRAMES, default 10, frames per +1 step while faster_key is held.
REQ-006 Parameter BRAKE_FRAMES, default 10, frames per -1 step while slower_key is held.
REQ-007 Parameter COAST_FRAMES, default 30, frames per -1 step while no key is held.
REQ-008 Parameter CRASH_HOLD_FRAMES, default 60, frames held at speed 0 after a crash.
REQ-009 clk  input  1  system clock; the only clock of the block.
REQ-010 resetN  input  1  synchronous reset, active low.
REQ-011 startOfFrame  input  1  frame pulse, synchronous to clk, may be several cycles wide.
REQ-012 faster_key  input  1  accelerate request, level.
REQ-013 slower_key  input  1  brake request, level.
REQ-014 crash  input  1  collision event, sampled every clk cycle.
REQ-015 speed  output  SPEED_W  current speed, registered.
REQ-016 at_max / at_min  output  1 each  speed==MAX_SPEED / speed==MIN_SPEED, combinational from the speed register.
REQ-017 crashed  output  1  high while state is CRASH.
REQ-018 recovering  output  1  high while state is RECOVER.

Function
REQ-019 The block SHALL contain a single clocked process on posedge clk; startOfFrame SHALL NOT be used as a clock.
REQ-020 tick = startOfFrame & ~sof_d, where sof_d is startOfFrame registered; exactly one tick per frame regardless of pulse width.
REQ-021 All state, counter and speed updates SHALL take effect at the clk edge closing the cycle in which tick=1 (1-clk latency); crash is the only input acting without a tick.
REQ-022 States: RUN, CRASH, RECOVER; reset state RUN.
REQ-023 RUN mode select per tick: faster_key -> ACCEL; else slower_key -> BRAKE; else COAST. faster_key wins when both are held.
REQ-024 Each mode has its own frame counter, 0..N-1. On a tick, the active counter increments; on the tick where it equals N-1, speed steps and the counter clears. Counters of inactive modes clear on every tick.
REQ-025 ACCEL step: +1 only if speed<MAX_SPEED. BRAKE and COAST step: -1 only if speed>MIN_SPEED. At a limit the counter still wraps and speed holds; no overflow or underflow.
REQ-026 crash=1 in any state and any cycle: next edge state<=CRASH, speed<=0, all counters clear.
REQ-027 CRASH: hold counter increments per tick; on the tick where it equals CRASH_HOLD_FRAMES-1, go to RECOVER. Keys are ignored. crash re-asserted restarts the hold from 0.
REQ-028 RECOVER: speed +1 on every tick. On the tick where speed+1==MIN_SPEED, load MIN_SPEED and go to RUN with all counters 0. Keys are ignored. crash returns to CRASH.
REQ-029 crash and tick in the same cycle: crash takes precedence and the tick has no other effect.
REQ-030 Legal parameters: MIN_SPEED>=1; MIN_SPEED<=INIT_SPEED<=MAX_SPEED<=2**SPEED_W-1; all *_FRAMES>=1. Counter widths are sized with $clog2 of the corresponding frame parameter.

Reset
REQ-031 resetN=0 at a clk edge: speed<=INIT_SPEED, state<=RUN, all counters<=0, sof_d<=0. crashed, recovering =0; at_min/at_max follow INIT_SPEED.
REQ-032 Reset SHALL override crash, tick and keys in the same cycle. Reset applied mid-frame or mid-CRASH fully aborts operation; no tick is generated from a startOfFrame already high when reset releases.

Verification
REQ-033 Defaults; hold faster_key for 10 ticks -> speed 12->13 exactly one clk after the 10th tick; hold 160 ticks -> speed saturates at 27, at_max=1.
REQ-034 At speed 20, hold faster_key and slower_key for 10 ticks -> speed 21; then slower_key only for 10 ticks -> 20; no key for 30 ticks -> 19.
REQ-035 startOfFrame held high for 5 clk per frame, faster_key held 10 frames -> exactly one increment (tick uniqueness).
REQ-036 At speed 25, crash for 1 cycle -> next edge speed=0, crashed=1. After 60 ticks, recovering=1 and speed climbs 1 per tick, reaching 12 on the 12th tick of RECOVER, then state RUN.
REQ-037 During RECOVER at speed 5, pulse crash -> speed 0, crashed=1, hold restarts a full 60 ticks.
REQ-038 Mid-CRASH, resetN=0 for 1 clk -> speed=12, crashed=0, counters 0; the first faster step occurs on the 10th subsequent tick.
